// File: rtl/speed_tick_gen.sv
// Purpose: debounced up/down/pause buttons steer a 3-bit speed level and a power-of-two tick period.
// Latency: button edge -> 2-flop sync -> DEB_CNT-cycle debounce -> level/paused update 1 cycle after the press strobe.
// Backpressure: none; tick is a free-running single-cycle strobe, suspended only while paused.
module speed_tick_gen #(
    parameter int DEB_CNT  = 20000,
    parameter int BASE_EXP = 13
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_pause,
    output logic       tick,
    output logic [2:0] speed_level,
    output logic       paused
);
    localparam int CNT_W = BASE_EXP + 7;
    localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ALL  = '1;

    // Debounce FSM states
    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
    localparam logic [1:0] ST_HELD        = 2'd2;
    localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

    // Button index 0 = up, 1 = down, 2 = pause
    logic [2:0]            sync1_q, sync1_d;
    logic [2:0]            sync2_q, sync2_d;
    logic [2:0][1:0]       deb_state_q, deb_state_d;
    logic [2:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]            press_evt;

    logic [2:0]            level_q, level_d;
    logic                  paused_q, paused_d;
    logic                  tick_q, tick_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      term;
    logic                  level_chg;

    // Two-flop synchronizer for the raw, asynchronous buttons
    always_comb begin
        sync1_d = {btn_pause, btn_down, btn_up};
        sync2_d = sync1_q;
    end

    // Per-button debounce: a level change is accepted only after DEB_CNT stable cycles;
    // the press strobe fires once, on the DEB_PRESS -> HELD transition.
    always_comb begin
        deb_state_d = deb_state_q;
        deb_cnt_d   = deb_cnt_q;
        press_evt   = '0;
        for (int i = 0; i < 3; i++) begin
            case (deb_state_q[i])
                ST_RELEASED: begin
                    if (sync2_q[i]) begin
                        deb_state_d[i] = ST_DEB_PRESS;
                        deb_cnt_d[i]   = '0;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!sync2_q[i]) begin
                        deb_state_d[i] = ST_RELEASED;
                    end else if (deb_cnt_q[i] == DEB_LAST) begin
                        deb_state_d[i] = ST_HELD;
                        press_evt[i]   = 1'b1;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!sync2_q[i]) begin
                        deb_state_d[i] = ST_DEB_RELEASE;
                        deb_cnt_d[i]   = '0;
                    end
                end
                ST_DEB_RELEASE: begin
                    if (sync2_q[i]) begin
                        deb_state_d[i] = ST_HELD;
                    end else if (deb_cnt_q[i] == DEB_LAST) begin
                        deb_state_d[i] = ST_RELEASED;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    deb_state_d[i] = ST_RELEASED;
                    deb_cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Speed level saturates at 0/7; simultaneous up+down cancel. Pause toggles independently.
    always_comb begin
        level_d = level_q;
        if (press_evt[0] && !press_evt[1] && (level_q != 3'd7)) begin
            level_d = level_q + 3'd1;
        end else if (press_evt[1] && !press_evt[0] && (level_q != 3'd0)) begin
            level_d = level_q - 3'd1;
        end
        paused_d  = paused_q ^ press_evt[2];
        level_chg = (level_d != level_q);
    end

    // Period counter: terminal value 2^(CNT_W-L)-1 is all-ones shifted right by L.
    // A real level change restarts the period, even while paused; pause freezes the count.
    always_comb begin
        term   = CNT_ALL >> level_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!paused_q) begin
            if (cnt_q == term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (level_chg) begin
            cnt_d = '0;
        end
    end

    // State registers; reset discards any pending debounce and partial period
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_state_q <= {3{ST_RELEASED}};
            deb_cnt_q   <= '0;
            level_q     <= 3'd3;
            paused_q    <= 1'b0;
            tick_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_state_q <= deb_state_d;
            deb_cnt_q   <= deb_cnt_d;
            level_q     <= level_d;
            paused_q    <= paused_d;
            tick_q      <= tick_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tick        = tick_q;
    assign speed_level = level_q;
    assign paused      = paused_q;

endmodule

// File: tb/tb_speed_tick_gen.sv
// Purpose: directed and random button stimulus against a run-length/countdown reference of speed_tick_gen.
// Latency: outputs sampled 1 time unit after each rising clk_in edge.
// Backpressure: none.
module tb_speed_tick_gen;
    localparam int DEB_CNT  = 4;
    localparam int BASE_EXP = 2;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_pause;
    logic       tick;
    logic [2:0] speed_level;
    logic       paused;

    int n_chk = 0;
    int n_err = 0;
    int tick_seen = 0;

    always #5 clk_in = ~clk_in;

    speed_tick_gen #(
        .DEB_CNT  (DEB_CNT),
        .BASE_EXP (BASE_EXP)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_pause   (btn_pause),
        .tick        (tick),
        .speed_level (speed_level),
        .paused      (paused)
    );

    // Reference model: a button level is accepted once the synchronized input has shown
    // the new value for DEB_CNT+1 consecutive samples (one to leave the idle state, DEB_CNT
    // to confirm). Ticks come from a countdown of cycles remaining in the current period.
    bit [2:0] m_s1, m_s2, m_deb;
    int       m_run1 [3];
    int       m_run0 [3];
    int       m_lvl;
    bit       m_paused;
    bit       m_tick;
    int       m_rem;

    function automatic int period_of(input int lvl);
        return 1 << (BASE_EXP + 7 - lvl);
    endfunction

    task automatic model_reset();
        m_s1     = '0;
        m_s2     = '0;
        m_deb    = '0;
        for (int i = 0; i < 3; i++) begin
            m_run1[i] = 0;
            m_run0[i] = 0;
        end
        m_lvl    = 3;
        m_paused = 1'b0;
        m_tick   = 1'b0;
        m_rem    = period_of(3);
    endtask

    task automatic model_edge(input bit [2:0] b);
        bit [2:0] x;
        bit [2:0] ev;
        int       nl;
        x    = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        ev   = '0;
        for (int i = 0; i < 3; i++) begin
            if (x[i]) begin
                m_run1[i]++;
                m_run0[i] = 0;
            end else begin
                m_run0[i]++;
                m_run1[i] = 0;
            end
            if (!m_deb[i] && m_run1[i] == DEB_CNT + 1) begin
                m_deb[i] = 1'b1;
                ev[i]    = 1'b1;
            end else if (m_deb[i] && m_run0[i] == DEB_CNT + 1) begin
                m_deb[i] = 1'b0;
            end
        end
        m_tick = 1'b0;
        if (!m_paused) begin
            m_rem--;
            if (m_rem == 0) begin
                m_tick = 1'b1;
                m_rem  = period_of(m_lvl);
            end
        end
        nl = m_lvl;
        if (ev[0] && !ev[1]) nl = (m_lvl < 7) ? m_lvl + 1 : 7;
        else if (ev[1] && !ev[0]) nl = (m_lvl > 0) ? m_lvl - 1 : 0;
        if (nl != m_lvl) begin
            m_lvl = nl;
            m_rem = period_of(nl);
        end
        if (ev[2]) m_paused = !m_paused;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outputs();
        chk("tick",        {31'b0, tick},        {31'b0, m_tick});
        chk("speed_level", {29'b0, speed_level}, 32'(m_lvl));
        chk("paused",      {31'b0, paused},      {31'b0, m_paused});
    endtask

    // One clock with buttons b = {pause, down, up}
    task automatic cyc(input bit [2:0] b);
        btn_up    = b[0];
        btn_down  = b[1];
        btn_pause = b[2];
        @(posedge clk_in);
        #1;
        model_edge(b);
        if (tick === 1'b1) tick_seen++;
        check_outputs();
    endtask

    task automatic rst_cyc();
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        model_reset();
        check_outputs();
    endtask

    task automatic press(input bit [2:0] b, input int hi, input int lo);
        repeat (hi) cyc(b);
        repeat (lo) cyc(3'b000);
    endtask

    int       t0;
    int       hold [3];
    bit [2:0] rb;

    initial begin
        reset     = 1'b1;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_pause = 1'b0;
        model_reset();

        // Reset values
        repeat (3) rst_cyc();
        reset = 1'b0;

        // Idle: ticks every 64 cycles at level 3
        t0 = tick_seen;
        repeat (200) cyc(3'b000);
        chk("idle_tick_count", 32'(tick_seen - t0), 32'd3);

        // One long press -> single increment; short glitch -> nothing
        press(3'b001, 10, 40);
        chk("up_once", {29'b0, speed_level}, 32'd4);
        press(3'b001, 2, 20);
        chk("glitch_ignored", {29'b0, speed_level}, 32'd4);

        // Saturate high, then saturate low
        repeat (5) press(3'b001, 8, 8);
        chk("sat_high", {29'b0, speed_level}, 32'd7);
        repeat (40) cyc(3'b000);
        repeat (9) press(3'b010, 8, 8);
        chk("sat_low", {29'b0, speed_level}, 32'd0);
        repeat (600) cyc(3'b000);

        // Pause mid-period: no ticks while paused, resume from held count
        repeat (100) cyc(3'b000);
        press(3'b100, 8, 0);
        chk("paused_on", {31'b0, paused}, 32'd1);
        t0 = tick_seen;
        repeat (1000) cyc(3'b000);
        chk("no_ticks_paused", 32'(tick_seen - t0), 32'd0);
        press(3'b100, 8, 0);
        chk("paused_off", {31'b0, paused}, 32'd0);
        repeat (600) cyc(3'b000);

        // Simultaneous up+down cancels
        repeat (2) press(3'b001, 8, 8);
        press(3'b011, 10, 40);
        chk("up_down_cancel", {29'b0, speed_level}, 32'd2);
        repeat (100) cyc(3'b000);

        // Reset mid-debounce and mid-period; held button re-debounced after release
        repeat (2) rst_cyc();
        reset = 1'b0;
        repeat (36) cyc(3'b000);
        repeat (4) cyc(3'b001);
        btn_up = 1'b1;
        repeat (3) rst_cyc();
        chk("reset_level", {29'b0, speed_level}, 32'd3);
        reset = 1'b0;
        repeat (20) cyc(3'b001);
        chk("held_through_reset", {29'b0, speed_level}, 32'd4);
        repeat (20) cyc(3'b000);

        // Random button activity
        for (int i = 0; i < 3; i++) hold[i] = 0;
        rb = '0;
        repeat (3000) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    rb[i]   = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 12);
                end
                hold[i]--;
            end
            cyc(rb);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
